div_bcd_fmt: RTL and testbench
==============================

Name: div_bcd_fmt

Overview:
- Downstream stage of the 8-bit sequential divider `div`.
- Captures the quotient Q and remainder R when the divider raises out_valid.
- Converts both values to 3-digit packed BCD with a sequential shift-add-3 (double-dabble) engine.
- Presents the BCD result to the display/report logic through a valid/ready handshake.

Parameters:
- WIDTH, 8, binary width of Q and R; equals the number of conversion iterations.
- DIGITS, 3, BCD digits per output. Requires 10^DIGITS > 2^WIDTH - 1; checked at elaboration, fatal if violated.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, divider out_valid.
- in_q, input, WIDTH, divider quotient Q.
- in_r, input, WIDTH, divider remainder R.
- q_bcd, output, 4*DIGITS, packed BCD of the captured Q; digit 0 in bits [3:0].
- r_bcd, output, 4*DIGITS, packed BCD of the captured R.
- out_valid, output, 1, q_bcd/r_bcd hold a finished result.
- out_ready, input, 1, consumer accepts the result.
- busy, output, 1, high in CONV or DONE.
- overrun, output, 1, sticky; a result was dropped.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; q_bcd, r_bcd, out_valid, busy, overrun = 0; iteration counter = 0.
  - in_valid edge-detect register = 0, so in_valid already high when rst releases counts as a new result.
- Capture event: in_valid=1 and previous-cycle in_valid=0 (rising edge only). The divider holds out_valid high for several cycles, so a held level captures exactly once.
- States and transitions:
  - IDLE:
    - On a capture event at edge N: load in_q/in_r into shift registers, clear the BCD accumulators, counter=0, go to CONV.
  - CONV:
    - One double-dabble step per cycle for both Q and R in parallel.
    - Each step: for every BCD digit >= 5 add 3, then shift {bcd, bin} left by 1.
    - Counter increments each step. After WIDTH steps (edge N+WIDTH), latch q_bcd/r_bcd, set out_valid=1, go to DONE.
    - Latency: capture edge to out_valid high = WIDTH cycles (8 by default).
  - DONE:
    - q_bcd, r_bcd and out_valid are held stable until out_valid && out_ready at an edge.
    - At that edge: out_valid=0 next cycle and go to IDLE.
    - q_bcd/r_bcd keep their last value until the next latch.
- out_ready is ignored outside DONE. The block has no combinational path from out_ready to any output.
- Capture event in CONV, or in DONE without handshake completion:
  - the new result is dropped;
  - overrun set to 1 (cleared only by rst);
  - the conversion in progress is unaffected.
- Simultaneous handshake completion and capture event in DONE: the new result is accepted, state goes directly to CONV, and out_valid drops the next cycle.
- busy = (state != IDLE), registered with state.
- Arithmetic: the add-3 correction is applied per 4-bit digit before the shift. Digits never exceed 9 after the final step. Inputs 0..2^WIDTH-1 are all legal.
- rst asserted mid-CONV or mid-DONE: the result is discarded, outputs return to reset values, and no stale out_valid appears after release.

Test Plan:
- Basic capture: in_q=1, in_r=35 (127/92), in_valid high 1 cycle, out_ready=1 -> out_valid high exactly 8 cycles after capture, q_bcd=12'h001, r_bcd=12'h035, then IDLE.
- Zero and exact-division values: in_q=0/in_r=0 (0/78), then in_q=8/in_r=0 (64/8), then in_q=1/in_r=0 (127/127), then in_q=0/in_r=1 (1/7) -> 12'h000/12'h000, 12'h008/12'h000, 12'h001/12'h000, 12'h000/12'h001. overrun stays 0.
- Maximum value: in_q=255, in_r=255 -> both outputs 12'h255. Also in_q=99, in_r=100 -> 12'h099, 12'h100.
- Held level and backpressure:
  - in_valid held high 20 cycles with in_q=64 -> exactly one conversion; q_bcd=12'h064.
  - out_ready=0 for 10 cycles after out_valid -> outputs stable; handshake on the first ready cycle.
- Overrun:
  - Second in_valid rising edge 3 cycles into CONV -> first result still correct, overrun=1.
  - Rising edge coincident with the DONE handshake -> accepted; the second result appears 8 cycles later.
- Reset mid-operation: rst pulse at CONV step 4 -> out_valid never rises for that result. A later capture of in_q=12, in_r=3 yields 12'h012/12'h003.

Source files
------------

// File: rtl/div_bcd_fmt.sv
// Result formatter behind the 8-bit sequential divider: captures Q/R on the
// divider's out_valid rising edge and converts both to packed BCD (double-dabble).
module div_bcd_fmt #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_q,
  input  logic [WIDTH-1:0]    in_r,
  output logic [4*DIGITS-1:0] q_bcd,
  output logic [4*DIGITS-1:0] r_bcd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                overrun,
  output logic [1:0]          state_dbg
);

  // Handshake: a result transfers on a rising clk edge where out_valid && out_ready;
  // out_valid and q_bcd/r_bcd are held stable until then, and out_valid never
  // depends combinationally on out_ready.

  localparam int BW   = 4 * DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_digits_too_few
    $fatal(1, "div_bcd_fmt: DIGITS too small to hold 2**WIDTH-1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]    q_sh, r_sh;
  logic [BW-1:0]       q_acc, r_acc;
  logic [CW-1:0]       cnt;
  logic                in_valid_d;
  logic [BW+WIDTH-1:0] q_step, r_step;
  logic                capture, hs, accept, drop;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] o;
    o = b;
    for (int d = 0; d < DIGITS; d++) begin
      if (b[4*d +: 4] >= 4'd5) o[4*d +: 4] = b[4*d +: 4] + 4'd3;
    end
    return o;
  endfunction

  // One double-dabble step: correct every digit, then shift {bcd, bin} left.
  assign q_step = {add3(q_acc), q_sh} << 1;
  assign r_step = {add3(r_acc), r_sh} << 1;

  assign capture = in_valid & ~in_valid_d;
  assign hs      = (state == DONE) & out_ready;
  assign accept  = capture & ((state == IDLE) | hs);
  assign drop    = capture & ~accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = CONV;
      CONV:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (hs) state_nxt = capture ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    state_dbg = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_sh       <= '0;
      r_sh       <= '0;
      q_acc      <= '0;
      r_acc      <= '0;
      cnt        <= '0;
      q_bcd      <= '0;
      r_bcd      <= '0;
      overrun    <= 1'b0;
      in_valid_d <= 1'b0;
    end else begin
      in_valid_d <= in_valid;
      if (drop) overrun <= 1'b1;
      if (accept) begin
        q_sh  <= in_q;
        r_sh  <= in_r;
        q_acc <= '0;
        r_acc <= '0;
        cnt   <= '0;
      end else if (state == CONV) begin
        {q_acc, q_sh} <= q_step;
        {r_acc, r_sh} <= r_step;
        cnt           <= cnt + 1'b1;
        if (cnt == LAST) begin
          q_bcd <= q_step[BW+WIDTH-1 -: BW];
          r_bcd <= r_step[BW+WIDTH-1 -: BW];
        end
      end
    end
  end

endmodule

// File: tb/tb_div_bcd_fmt.sv
// Directed bench for div_bcd_fmt: decimal-arithmetic model checked every cycle
// plus literal expectations for each directed scenario.
module tb_div_bcd_fmt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_q = '0;
  logic [7:0]  in_r = '0;
  logic [11:0] q_bcd, r_bcd;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, overrun;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  div_bcd_fmt #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_q(in_q), .in_r(in_r),
    .q_bcd(q_bcd), .r_bcd(r_bcd), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [11:0] bcd3(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [11:0] exp_q[$];
  logic [11:0] exp_r[$];
  logic [11:0] last_q = '0, last_r = '0;
  logic        outstanding = 1'b0, m_overrun = 1'b0, tb_prev = 1'b0;
  logic        exp_valid, rising, m_hs;
  int          ready_at = 0;

  always @(negedge clk) begin
    if (rst) begin
      outstanding = 1'b0;
      m_overrun   = 1'b0;
      last_q      = '0;
      last_r      = '0;
      tb_prev     = 1'b0;
      exp_q.delete();
      exp_r.delete();
    end
    exp_valid = outstanding && (cyc >= ready_at);
    check("m_out_valid", out_valid, exp_valid);
    check("m_busy", busy, outstanding);
    check("m_overrun", overrun, m_overrun);
    check("m_q_bcd", q_bcd, exp_valid ? exp_q[0] : last_q);
    check("m_r_bcd", r_bcd, exp_valid ? exp_r[0] : last_r);
    if (!rst) begin
      rising = in_valid && !tb_prev;
      m_hs   = exp_valid && out_ready;
      if (m_hs) begin
        outstanding = 1'b0;
        last_q = exp_q.pop_front();
        last_r = exp_r.pop_front();
      end
      if (rising) begin
        if (!outstanding) begin
          exp_q.push_back(bcd3(int'(in_q)));
          exp_r.push_back(bcd3(int'(in_r)));
          ready_at    = cyc + 9;
          outstanding = 1'b1;
        end else begin
          m_overrun = 1'b1;
        end
      end
      tb_prev = in_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] q, input logic [7:0] r, input int len);
    in_q = q;
    in_r = r;
    in_valid = 1'b1;
    repeat (len) tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [11:0] eq, input logic [11:0] er, input string tag);
    int n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", tag, n);
    end else begin
      check({tag, "_q"}, q_bcd, eq);
      check({tag, "_r"}, r_bcd, er);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int nv;
    check("model_255", bcd3(255), 12'h255);
    check("model_099", bcd3(99), 12'h099);
    check("model_100", bcd3(100), 12'h100);

    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_q_bcd", q_bcd, 12'h000);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    // basic capture 127/92
    pulse(8'd1, 8'd35, 1);
    repeat (6) begin
      check("basic_pre_valid", out_valid, 1'b0);
      tick();
    end
    tick();
    wait_done(12'h001, 12'h035, "basic");
    tick();
    check("basic_idle", busy, 1'b0);

    // zero and exact-division values
    pulse(8'd0, 8'd0, 1);   wait_done(12'h000, 12'h000, "zero00"); tick();
    pulse(8'd8, 8'd0, 1);   wait_done(12'h008, 12'h000, "zero80"); tick();
    pulse(8'd1, 8'd0, 1);   wait_done(12'h001, 12'h000, "zero10"); tick();
    pulse(8'd0, 8'd1, 1);   wait_done(12'h000, 12'h001, "zero01"); tick();
    check("zero_overrun", overrun, 1'b0);

    // maximum and digit-boundary values
    pulse(8'd255, 8'd255, 1); wait_done(12'h255, 12'h255, "max"); tick();
    pulse(8'd99, 8'd100, 1);  wait_done(12'h099, 12'h100, "b99"); tick();

    // held level: exactly one conversion
    in_q = 8'd64;
    in_r = 8'd0;
    in_valid = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) nv++;
    end
    in_valid = 1'b0;
    check("held_count", nv, 1);
    check("held_q", q_bcd, 12'h064);
    tick();

    // backpressure
    out_ready = 1'b0;
    pulse(8'd123, 8'd45, 1);
    wait_done(12'h123, 12'h045, "bp");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_q", q_bcd, 12'h123);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", out_valid, 1'b0);
    tick();

    // overrun: second edge 3 cycles into CONV
    pulse(8'd200, 8'd7, 1);
    tick();
    tick();
    pulse(8'd77, 8'd77, 1);
    wait_done(12'h200, 12'h007, "ovr");
    check("ovr_flag", overrun, 1'b1);
    tick();
    tick();

    // capture coincident with DONE handshake
    out_ready = 1'b0;
    pulse(8'd5, 8'd6, 1);
    wait_done(12'h005, 12'h006, "coin_a");
    in_q = 8'd42;
    in_r = 8'd9;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("coin_drop", out_valid, 1'b0);
    check("coin_busy", busy, 1'b1);
    wait_done(12'h042, 12'h009, "coin_b");
    tick();
    tick();

    // reset mid-conversion
    pulse(8'd50, 8'd50, 1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("midrst_no_stale", out_valid, 1'b0);
    end
    pulse(8'd12, 8'd3, 1);
    wait_done(12'h012, 12'h003, "post_rst");
    check("post_rst_overrun", overrun, 1'b0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
